// File: rtl/outputc_vc_pkg.sv
// -----------------------------------------------------------------------------
// outputc_vc_pkg
// Shared definitions for the router output-channel stage:
//   - flit-type field placement (type field sits in the top bits of a flit)
//   - Enable/Disable constants
//   - default DATAW / DEPTH / PKTLEN
//   - credit-counter operation encoding and its decode helper
// -----------------------------------------------------------------------------
package outputc_vc_pkg;

    // Default configuration
    localparam int DEF_DATAW  = 64;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_PKTLEN = 4;

    // Generic on/off constants
    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    // Flit-type field: FTYPE_W bits at the top of the flit
    localparam int FTYPE_W = 2;

    typedef enum logic [1:0] {
        FT_HEAD     = 2'd0,
        FT_BODY     = 2'd1,
        FT_TAIL     = 2'd2,
        FT_HEADTAIL = 2'd3
    } flit_type_e;

    // Bit positions of the type field for a given flit width
    function automatic int ftype_msb(input int dataw);
        return dataw - 1;
    endfunction

    function automatic int ftype_lsb(input int dataw);
        return dataw - FTYPE_W;
    endfunction

    // What the per-VC credit counter does this cycle
    typedef enum logic [1:0] {
        CR_HOLD = 2'd0,
        CR_INC  = 2'd1,
        CR_DEC  = 2'd2
    } credit_op_e;

    // A send and an ack in the same cycle cancel out. The counter saturates
    // at both ends instead of wrapping.
    function automatic credit_op_e credit_op(input logic send,
                                             input logic ack,
                                             input logic empty,
                                             input logic full);
        credit_op_e op;
        if (send && !ack && !full) begin
            op = CR_INC;
        end else if (ack && !send && !empty) begin
            op = CR_DEC;
        end else begin
            op = CR_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/outputc_vc_if.sv
// -----------------------------------------------------------------------------
// outputc_vc_if
// Bundle of the crossbar-side, link-side and allocator-side signals of one
// router output channel.
//   idata/ivalid/ivch : flit from the crossbar
//   odata/ovalid/ovch : registered flit onto the link
//   iack              : per-VC credit return from downstream
//   ordy              : per-VC "room for a full packet"
//   ilck / olck       : downstream lock state in, local lock view out
//   err               : per-VC sticky credit error
// Modports: slave = the output channel itself, master = its environment.
// -----------------------------------------------------------------------------
interface outputc_vc_if #(
    parameter int NVC   = 2,
    parameter int DATAW = 64,
    parameter int VCW   = (NVC > 1) ? $clog2(NVC) : 1
);
    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VCW-1:0]   ivch;
    logic [DATAW-1:0] odata;
    logic             ovalid;
    logic [VCW-1:0]   ovch;
    logic [NVC-1:0]   iack;
    logic [NVC-1:0]   ordy;
    logic [NVC-1:0]   ilck;
    logic [NVC-1:0]   olck;
    logic [NVC-1:0]   err;

    modport slave (
        input  idata, ivalid, ivch, iack, ilck,
        output odata, ovalid, ovch, ordy, olck, err
    );

    modport master (
        output idata, ivalid, ivch, iack, ilck,
        input  odata, ovalid, ovch, ordy, olck, err
    );

endinterface

// File: rtl/outputc_vc_credit.sv
// -----------------------------------------------------------------------------
// outputc_vc_credit
// Credit counter, ready flag, lock tracker and credit-error flag of one VC.
// Optional feature macro: OUTPUTC_VC_ERRCHK_EN (sticky under/overflow flag).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   send_i    : a flit for this VC is accepted this cycle
//   ack_i     : downstream freed one slot of this VC
//   link_i    : the flit currently on the link belongs to this VC
//   ilck_i    : downstream still holds this VC locked
//   ordy_o    : room downstream for a full packet
//   olck_o    : local lock view
//   err_o     : sticky credit error (0 when the check is not built)
// -----------------------------------------------------------------------------
import outputc_vc_pkg::*;

module outputc_vc_credit #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int VC       = 0,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PKTLEN   = DEF_PKTLEN,
    parameter int CNTW     = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic send_i,
    input  logic ack_i,
    input  logic link_i,
    input  logic ilck_i,
    output logic ordy_o,
    output logic olck_o,
    output logic err_o
);

    // Free-space arithmetic gets one extra bit so DEPTH - cnt never wraps
    localparam int FW = CNTW + 1;

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            olck_q;
    logic            olck_d;
    logic            empty_s;
    logic            full_s;
    credit_op_e      op_s;
    logic [FW-1:0]   free_s;

    assign empty_s = (cnt_q == {CNTW{1'b0}});
    assign full_s  = (cnt_q == CNTW'(DEPTH));
    assign op_s    = credit_op(send_i, ack_i, empty_s, full_s);

    // Next value of the outstanding-flit counter
    always_comb begin
        cnt_d = cnt_q;
        case (op_s)
            CR_INC:  cnt_d = cnt_q + CNTW'(1);
            CR_DEC:  cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding-flit counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNTW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Ready only when a whole packet fits, since allocators commit per packet
    assign free_s = FW'(DEPTH) - {1'b0, cnt_q};
    assign ordy_o = (free_s >= FW'(PKTLEN));

    // Lock next state: a new or in-flight flit keeps the VC locked, which
    // takes priority over downstream releasing it
    always_comb begin
        olck_d = olck_q;
        if (send_i || link_i) begin
            olck_d = 1'b1;
        end else if (olck_q && !ilck_i) begin
            olck_d = 1'b0;
        end else begin
            olck_d = olck_q;
        end
    end

    // Lock register
    always_ff @(posedge clk) begin
        if (rst) begin
            olck_q <= 1'b0;
        end else begin
            olck_q <= olck_d;
        end
    end

    assign olck_o = olck_q;

`ifdef OUTPUTC_VC_ERRCHK_EN
    logic err_q;
    logic underflow_s;
    logic overflow_s;

    assign underflow_s = ack_i && !send_i && empty_s;
    assign overflow_s  = send_i && !ack_i && full_s;

    // Sticky credit-error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (underflow_s || overflow_s) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign err_o = err_q;

`ifndef SYNTHESIS
    // Simulation report identifying where the credit error happened
    always_ff @(posedge clk) begin
        if (!rst && (underflow_s || overflow_s)) begin
            $error("outputc_vc router %0d pch %0d vc %0d: credit %s",
                   ROUTERID, PCHID, VC, underflow_s ? "underflow" : "overflow");
        end
    end
`endif
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/outputc_vc.sv
// -----------------------------------------------------------------------------
// outputc_vc
// Router output-channel stage: registers the switch-allocated flit onto the
// physical link and tracks downstream credit and lock state per VC.
// Optional feature macro: OUTPUTC_VC_ERRCHK_EN (per-VC sticky credit error).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : outputc_vc_if.slave (flit in/out, iack/ordy, ilck/olck, err)
// -----------------------------------------------------------------------------
import outputc_vc_pkg::*;

module outputc_vc #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int NVC      = 2,
    parameter int VCW      = (NVC > 1) ? $clog2(NVC) : 1,
    parameter int DATAW    = DEF_DATAW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PKTLEN   = DEF_PKTLEN,
    parameter int CNTW     = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    outputc_vc_if.slave bus
);

    logic [DATAW-1:0] odata_q;
    logic [DATAW-1:0] odata_d;
    logic             ovalid_q;
    logic             ovalid_d;
    logic [VCW-1:0]   ovch_q;
    logic [VCW-1:0]   ovch_d;
    logic [NVC-1:0]   send_s;
    logic [NVC-1:0]   link_s;
    logic [NVC-1:0]   ordy_s;
    logic [NVC-1:0]   olck_s;
    logic [NVC-1:0]   err_s;

    // Link register next state: load a new flit, otherwise drop to all-zero
    // after the last one, otherwise stay idle
    always_comb begin
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        ovch_d   = ovch_q;
        if (bus.ivalid) begin
            odata_d  = bus.idata;
            ovalid_d = 1'b1;
            ovch_d   = bus.ivch;
        end else if (ovalid_q) begin
            odata_d  = {DATAW{1'b0}};
            ovalid_d = 1'b0;
            ovch_d   = {VCW{1'b0}};
        end else begin
            odata_d  = odata_q;
            ovalid_d = ovalid_q;
            ovch_d   = ovch_q;
        end
    end

    // Link register
    always_ff @(posedge clk) begin
        if (rst) begin
            odata_q  <= {DATAW{1'b0}};
            ovalid_q <= 1'b0;
            ovch_q   <= {VCW{1'b0}};
        end else begin
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
        end
    end

    // Per-VC decode and credit/lock tracking. A VC index at or above NVC
    // matches no generate slot, so it touches no counter.
    for (genvar v = 0; v < NVC; v++) begin : g_vc
        assign send_s[v] = bus.ivalid && (bus.ivch == VCW'(v));
        assign link_s[v] = ovalid_q && (ovch_q == VCW'(v));

        outputc_vc_credit #(
            .ROUTERID (ROUTERID),
            .PCHID    (PCHID),
            .VC       (v),
            .DEPTH    (DEPTH),
            .PKTLEN   (PKTLEN),
            .CNTW     (CNTW)
        ) u_credit (
            .clk    (clk),
            .rst    (rst),
            .send_i (send_s[v]),
            .ack_i  (bus.iack[v]),
            .link_i (link_s[v]),
            .ilck_i (bus.ilck[v]),
            .ordy_o (ordy_s[v]),
            .olck_o (olck_s[v]),
            .err_o  (err_s[v])
        );
    end

    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.ovch   = ovch_q;
    assign bus.ordy   = ordy_s;
    assign bus.olck   = olck_s;
    assign bus.err    = err_s;

endmodule
